// File: rtl/food_placer_if.sv
// Bus between food_placer and its environment: request/random inputs, occupancy RAM port, food outputs.
interface food_placer_if;
  logic       place_req;
  logic [9:0] rand_x;
  logic [8:0] rand_y;
  logic       occ_rd;
  logic [11:0] occ_addr;
  logic       occ_hit;
  logic [5:0] food_cx;
  logic [5:0] food_cy;
  logic [9:0] food_px;
  logic [8:0] food_py;
  logic       food_valid;
  logic       busy;
  logic       grid_full;

  modport master (
    output place_req, rand_x, rand_y, occ_hit,
    input  occ_rd, occ_addr, food_cx, food_cy, food_px, food_py, food_valid, busy, grid_full
  );

  modport slave (
    input  place_req, rand_x, rand_y, occ_hit,
    output occ_rd, occ_addr, food_cx, food_cy, food_px, food_py, food_valid, busy, grid_full
  );
endinterface

// File: rtl/food_placer.sv
// Picks a free food cell: random candidates checked against snake occupancy,
// falling back to a linear scan after MAX_TRIES failures.
module food_placer #(
  parameter int unsigned ROWS      = 48,
  parameter int unsigned CELL_PX   = 10,
  parameter int unsigned MAX_TRIES = 8
) (
  input  logic         clk,
  input  logic         rst,
  food_placer_if.slave bus
);

  localparam int unsigned CELLS = 64 * ROWS;
  localparam int unsigned SW    = $clog2(CELLS + 1);
  localparam int unsigned TW    = $clog2(MAX_TRIES + 1);

  localparam logic [5:0]    ROWS6    = 6'(ROWS);
  localparam logic [5:0]    LAST_ROW = 6'(ROWS - 1);
  localparam logic [TW-1:0] TRY_LIM  = TW'(MAX_TRIES);
  localparam logic [SW-1:0] SCAN_LIM = SW'(CELLS);
  localparam logic [9:0]    CPX10    = 10'(CELL_PX);
  localparam logic [8:0]    CPX9     = 9'(CELL_PX);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SAMPLE = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] CHECK  = 3'd3;
  localparam logic [2:0] SCAN   = 3'd4;
  localparam logic [2:0] SWAIT  = 3'd5;
  localparam logic [2:0] SCHECK = 3'd6;

  logic [2:0]    state, state_nx;
  logic [TW-1:0] try_cnt, try_nx;
  logic [SW-1:0] scan_cnt, scan_nx;
  logic [5:0]    cand_cx, cand_cx_nx, cand_cy, cand_cy_nx;
  logic          occ_rd_nx;
  logic [11:0]   occ_addr_nx;
  logic [5:0]    food_cx_nx, food_cy_nx;
  logic [9:0]    food_px_nx;
  logic [8:0]    food_py_nx;
  logic          food_valid_nx, busy_nx, grid_full_nx;

  // Only the low six bits of the random coordinates address the grid.
  logic unused_rand;
  assign unused_rand = ^{bus.rand_x[9:6], bus.rand_y[8:6]};

  always_comb begin
    state_nx      = state;
    try_nx        = try_cnt;
    scan_nx       = scan_cnt;
    cand_cx_nx    = cand_cx;
    cand_cy_nx    = cand_cy;
    occ_rd_nx     = 1'b0;
    occ_addr_nx   = bus.occ_addr;
    food_cx_nx    = bus.food_cx;
    food_cy_nx    = bus.food_cy;
    food_px_nx    = bus.food_px;
    food_py_nx    = bus.food_py;
    food_valid_nx = bus.food_valid;
    busy_nx       = bus.busy;
    grid_full_nx  = bus.grid_full;

    case (state)
      IDLE: begin
        if (bus.place_req) begin
          food_valid_nx = 1'b0;
          grid_full_nx  = 1'b0;
          busy_nx       = 1'b1;
          try_nx        = '0;
          state_nx      = SAMPLE;
        end
      end
      SAMPLE: begin
        cand_cx_nx = bus.rand_x[5:0];
        cand_cy_nx = bus.rand_y[5:0];
        if (bus.rand_y[5:0] >= ROWS6) begin
          try_nx = try_cnt + TW'(1);
          if (try_nx == TRY_LIM) begin
            scan_nx  = '0;
            state_nx = SCAN;
          end
        end else begin
          occ_addr_nx = {bus.rand_y[5:0], bus.rand_x[5:0]};
          occ_rd_nx   = 1'b1;
          state_nx    = WAIT;
        end
      end
      WAIT: state_nx = CHECK;
      CHECK: begin
        if (!bus.occ_hit) begin
          food_cx_nx    = cand_cx;
          food_cy_nx    = cand_cy;
          food_px_nx    = {4'd0, cand_cx} * CPX10;
          food_py_nx    = {3'd0, cand_cy} * CPX9;
          food_valid_nx = 1'b1;
          busy_nx       = 1'b0;
          state_nx      = IDLE;
        end else begin
          try_nx = try_cnt + TW'(1);
          if (try_nx == TRY_LIM) begin
            scan_nx  = '0;
            state_nx = SCAN;
          end else begin
            state_nx = SAMPLE;
          end
        end
      end
      SCAN: begin
        // Raster-order successor of the last candidate; an off-grid row restarts at the origin.
        if (cand_cy >= ROWS6) begin
          cand_cx_nx = '0;
          cand_cy_nx = '0;
        end else if (cand_cx == 6'd63) begin
          cand_cx_nx = '0;
          cand_cy_nx = (cand_cy == LAST_ROW) ? 6'd0 : cand_cy + 6'd1;
        end else begin
          cand_cx_nx = cand_cx + 6'd1;
        end
        occ_addr_nx = {cand_cy_nx, cand_cx_nx};
        occ_rd_nx   = 1'b1;
        state_nx    = SWAIT;
      end
      SWAIT: state_nx = SCHECK;
      SCHECK: begin
        if (!bus.occ_hit) begin
          food_cx_nx    = cand_cx;
          food_cy_nx    = cand_cy;
          food_px_nx    = {4'd0, cand_cx} * CPX10;
          food_py_nx    = {3'd0, cand_cy} * CPX9;
          food_valid_nx = 1'b1;
          busy_nx       = 1'b0;
          state_nx      = IDLE;
        end else begin
          scan_nx = scan_cnt + SW'(1);
          if (scan_nx == SCAN_LIM) begin
            grid_full_nx = 1'b1;
            busy_nx      = 1'b0;
            state_nx     = IDLE;
          end else begin
            state_nx = SCAN;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      try_cnt        <= '0;
      scan_cnt       <= '0;
      cand_cx        <= '0;
      cand_cy        <= '0;
      bus.occ_rd     <= 1'b0;
      bus.occ_addr   <= '0;
      bus.food_cx    <= '0;
      bus.food_cy    <= '0;
      bus.food_px    <= '0;
      bus.food_py    <= '0;
      bus.food_valid <= 1'b0;
      bus.busy       <= 1'b0;
      bus.grid_full  <= 1'b0;
    end else begin
      state          <= state_nx;
      try_cnt        <= try_nx;
      scan_cnt       <= scan_nx;
      cand_cx        <= cand_cx_nx;
      cand_cy        <= cand_cy_nx;
      bus.occ_rd     <= occ_rd_nx;
      bus.occ_addr   <= occ_addr_nx;
      bus.food_cx    <= food_cx_nx;
      bus.food_cy    <= food_cy_nx;
      bus.food_px    <= food_px_nx;
      bus.food_py    <= food_py_nx;
      bus.food_valid <= food_valid_nx;
      bus.busy       <= busy_nx;
      bus.grid_full  <= grid_full_nx;
    end
  end

endmodule

// File: tb/tb_food_placer.sv
// Scoreboard bench for food_placer: directed placements with expected lookups and commits queued.
module tb_food_placer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst_q = 1'b1;
  always #5 clk = ~clk;

  food_placer_if bus();

  food_placer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          at;
    logic [11:0] addr;
  } rd_t;

  typedef struct {
    int         at;
    bit         full;
    logic [5:0] cx;
    logic [5:0] cy;
    logic [9:0] px;
    logic [8:0] py;
  } done_t;

  rd_t   rdq[$];
  done_t dq[$];
  rd_t   mr;
  done_t md;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t0 = 0;
  int mode = 0;
  bit prev_busy = 1'b0;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // 0: all free, 1: only (5,5) occupied, 2: all occupied except (12,3), 3: all occupied
  function automatic bit occupied(input logic [11:0] a);
    case (mode)
      0:       return 1'b0;
      1:       return a == {6'd5, 6'd5};
      2:       return a != {6'd3, 6'd12};
      default: return 1'b1;
    endcase
  endfunction

  always @(posedge clk) bus.occ_hit <= bus.occ_rd ? occupied(bus.occ_addr) : 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push_rd(input int at, input logic [5:0] cx, input logic [5:0] cy);
    rd_t r;
    r.at = at;
    r.addr = {cy, cx};
    rdq.push_back(r);
  endtask

  task automatic push_done(input int at, input bit full, input logic [5:0] cx, input logic [5:0] cy,
                           input logic [9:0] px, input logic [8:0] py);
    done_t d;
    d.at = at; d.full = full; d.cx = cx; d.cy = cy; d.px = px; d.py = py;
    dq.push_back(d);
  endtask

  // Monitor: pops expected lookups on occ_rd and expected results when busy falls.
  always @(negedge clk) begin
    if (!rst_q) begin
      if (bus.occ_rd) begin
        if (rdq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rd actual addr %0h required no lookup", bus.occ_addr);
        end else begin
          mr = rdq.pop_front();
          chk("rd_addr", 32'(bus.occ_addr), 32'(mr.addr));
          chk("rd_cycle", cyc - t0, mr.at);
        end
      end
      if (!prev_busy && bus.busy) begin
        chk("busy_rise_cycle", cyc - t0, 1);
        chk("busy_rise_valid", 32'(bus.food_valid), 0);
        chk("busy_rise_full", 32'(bus.grid_full), 0);
      end
      if (prev_busy && !bus.busy) begin
        if (dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual busy fell required still idle");
        end else begin
          md = dq.pop_front();
          chk("done_cycle", cyc - t0, md.at);
          chk("done_valid", 32'(bus.food_valid), 32'(!md.full));
          chk("done_full", 32'(bus.grid_full), 32'(md.full));
          chk("done_cx", 32'(bus.food_cx), 32'(md.cx));
          chk("done_cy", 32'(bus.food_cy), 32'(md.cy));
          chk("done_px", 32'(bus.food_px), 32'(md.px));
          chk("done_py", 32'(bus.food_py), 32'(md.py));
        end
      end
    end
    prev_busy <= bus.busy;
  end

  task automatic start(input int hold);
    @(negedge clk);
    t0 = cyc;
    bus.place_req = 1'b1;
    repeat (hold) @(negedge clk);
    bus.place_req = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while ((rdq.size() != 0 || dq.size() != 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (rdq.size() != 0 || dq.size() != 0) begin
      checks++; errors++;
      $display("FAIL timeout actual pending %0d required 0", rdq.size() + dq.size());
      rdq.delete();
      dq.delete();
    end
    repeat (6) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_occ_rd"}, 32'(bus.occ_rd), 0);
    chk({tag, "_occ_addr"}, 32'(bus.occ_addr), 0);
    chk({tag, "_food_valid"}, 32'(bus.food_valid), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_grid_full"}, 32'(bus.grid_full), 0);
    chk({tag, "_food_cx"}, 32'(bus.food_cx), 0);
    chk({tag, "_food_cy"}, 32'(bus.food_cy), 0);
    chk({tag, "_food_px"}, 32'(bus.food_px), 0);
    chk({tag, "_food_py"}, 32'(bus.food_py), 0);
  endtask

  initial begin
    bus.place_req = 1'b0;
    bus.rand_x = '0;
    bus.rand_y = '0;
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // First-try success
    mode = 0; bus.rand_x = 10'd37; bus.rand_y = 9'd20;
    push_rd(2, 6'd37, 6'd20);
    push_done(4, 1'b0, 6'd37, 6'd20, 10'd370, 9'd200);
    start(1);
    wait_done(50);

    // Reset while waiting on the occupancy lookup
    bus.rand_x = 10'd1; bus.rand_y = 9'd2;
    push_rd(2, 6'd1, 6'd2);
    start(1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Two off-grid rows, one collision, then a free cell; upper random bits ignored
    mode = 1; bus.rand_x = 10'd0; bus.rand_y = 9'd50;
    push_rd(4, 6'd5, 6'd5);
    push_rd(7, 6'd6, 6'd7);
    push_done(9, 1'b0, 6'd6, 6'd7, 10'd60, 9'd70);
    start(1);
    @(negedge clk);
    bus.rand_y = 9'd114;
    @(negedge clk);
    bus.rand_x = 10'd517; bus.rand_y = 9'd5;
    @(negedge clk);
    bus.rand_x = 10'd6; bus.rand_y = 9'd7;
    wait_done(100);

    // Random tries exhausted, scan finds (12,3)
    mode = 2; bus.rand_x = 10'd10; bus.rand_y = 9'd3;
    for (int k = 0; k < 8; k++) push_rd(2 + 3 * k, 6'd10, 6'd3);
    push_rd(26, 6'd11, 6'd3);
    push_rd(29, 6'd12, 6'd3);
    push_done(31, 1'b0, 6'd12, 6'd3, 10'd120, 9'd30);
    start(1);
    wait_done(200);

    // place_req held through the search is ignored; maximal cell coordinates
    mode = 0; bus.rand_x = 10'd63; bus.rand_y = 9'd47;
    push_rd(2, 6'd63, 6'd47);
    push_done(4, 1'b0, 6'd63, 6'd47, 10'd630, 9'd470);
    start(4);
    wait_done(50);

    // Fully occupied grid: 8 random lookups, full raster scan, food outputs hold
    mode = 3; bus.rand_x = 10'd0; bus.rand_y = 9'd0;
    for (int k = 0; k < 8; k++) push_rd(2 + 3 * k, 6'd0, 6'd0);
    for (int i = 1; i <= 3072; i++) begin
      int idx;
      idx = i % 3072;
      push_rd(2 + 3 * (7 + i), 6'(idx % 64), 6'(idx / 64));
    end
    push_done(2 + 3 * 3079 + 2, 1'b1, 6'd63, 6'd47, 10'd630, 9'd470);
    start(1);
    wait_done(10000);

    // Next request clears grid_full
    mode = 0; bus.rand_x = 10'd1; bus.rand_y = 9'd1;
    push_rd(2, 6'd1, 6'd1);
    push_done(4, 1'b0, 6'd1, 6'd1, 10'd10, 9'd10);
    start(1);
    wait_done(50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
